// File: rtl/pipe_mem_lsu.sv
// pipe_mem_lsu: Memory-stage load/store unit for the pipelined RV32I core.
// Converts a Memory-stage load/store into a req/gnt/rvalid transaction on a
// variable-latency data memory, stalls the pipeline while it is outstanding,
// builds store byte lanes, formats load data and reports misaligned accesses
// and bus timeouts alongside a one-cycle completion pulse.
module pipe_mem_lsu #(
    parameter int XLEN           = 32,
    parameter int DMEM_ADDR_BIT  = 14,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_lsu_valid,
    input  logic                     i_lsu_we,
    input  logic [2:0]               i_lsu_funct3,
    input  logic [XLEN-1:0]          i_lsu_addr,
    input  logic [XLEN-1:0]          i_lsu_wdata,
    input  logic                     i_lsu_flush,
    output logic                     o_lsu_stall,
    output logic                     o_lsu_done,
    output logic [XLEN-1:0]          o_lsu_rdata,
    output logic                     o_lsu_misalign,
    output logic                     o_lsu_err,
    output logic                     o_dmem_req,
    input  logic                     i_dmem_gnt,
    output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
    output logic                     o_dmem_wen,
    output logic [3:0]               o_dmem_byte_sel,
    output logic [XLEN-1:0]          o_dmem_wdata,
    input  logic                     i_dmem_rvalid,
    input  logic [XLEN-1:0]          i_dmem_rdata
);

    // Timeout counter must be able to hold TIMEOUT_CYCLES-1; a zero setting
    // disables the timeout entirely.
    localparam int            TW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [DMEM_ADDR_BIT-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [3:0]               sel_q, sel_d;
    logic [XLEN-1:0]          wdata_q, wdata_d;
    logic [XLEN-1:0]          rdata_q, rdata_d;
    logic                     misalign_q, misalign_d;
    logic                     err_q, err_d;
    logic [TW-1:0]            tcnt_q, tcnt_d;

    logic                     req_illegal;
    logic [3:0]               req_sel;
    logic [XLEN-1:0]          req_wdata;
    logic [7:0]               lane_byte;
    logic [15:0]              lane_half;
    logic [XLEN-1:0]          load_fmt;
    logic                     tmo_hit;

    // Address bits above the decoded memory range are deliberately dropped.
    logic                     unused_addr_hi;
    assign unused_addr_hi = ^i_lsu_addr[XLEN-1:DMEM_ADDR_BIT];

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == T_LAST);

    // Decode the incoming request: legality, store byte lanes and replicated store data.
    always_comb begin
        req_illegal = 1'b0;
        req_sel     = 4'b1111;
        req_wdata   = i_lsu_wdata;
        case (i_lsu_funct3)
            F3_B: begin
                if (i_lsu_we) begin
                    req_sel   = 4'b0001 << i_lsu_addr[1:0];
                    req_wdata = {4{i_lsu_wdata[7:0]}};
                end
            end
            F3_H: begin
                req_illegal = i_lsu_addr[0];
                if (i_lsu_we) begin
                    req_sel   = 4'b0011 << {i_lsu_addr[1], 1'b0};
                    req_wdata = {2{i_lsu_wdata[15:0]}};
                end
            end
            F3_W:    req_illegal = |i_lsu_addr[1:0];
            F3_BU:   req_illegal = i_lsu_we;
            F3_HU:   req_illegal = i_lsu_we | i_lsu_addr[0];
            default: req_illegal = 1'b1;
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it per funct3.
    always_comb begin
        lane_byte = i_dmem_rdata[7:0];
        case (addr_q[1:0])
            2'd0:    lane_byte = i_dmem_rdata[7:0];
            2'd1:    lane_byte = i_dmem_rdata[15:8];
            2'd2:    lane_byte = i_dmem_rdata[23:16];
            default: lane_byte = i_dmem_rdata[31:24];
        endcase
        lane_half = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (funct3_q)
            F3_B:    load_fmt = {{(XLEN-8){lane_byte[7]}}, lane_byte};
            F3_H:    load_fmt = {{(XLEN-16){lane_half[15]}}, lane_half};
            F3_BU:   load_fmt = {{(XLEN-8){1'b0}}, lane_byte};
            F3_HU:   load_fmt = {{(XLEN-16){1'b0}}, lane_half};
            default: load_fmt = i_dmem_rdata;
        endcase
    end

    // Next-state logic: accept, bus handshake, timeout and completion.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        err_d      = err_q;
        tcnt_d     = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_lsu_valid) begin
                    addr_d     = i_lsu_addr[DMEM_ADDR_BIT-1:0];
                    we_d       = i_lsu_we;
                    funct3_d   = i_lsu_funct3;
                    sel_d      = req_sel;
                    wdata_d    = req_wdata;
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    misalign_d = req_illegal;
                    tcnt_d     = '0;
                    state_d    = req_illegal ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (i_dmem_gnt) begin
                    tcnt_d  = '0;
                    state_d = we_q ? S_DONE : S_WAIT;
                end else if (i_lsu_flush) begin
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_WAIT: begin
                if (i_dmem_rvalid) begin
                    rdata_d = load_fmt;
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_DONE: begin
                rdata_d    = '0;
                misalign_d = 1'b0;
                err_d      = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers; reset drops any access in flight immediately.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            sel_q      <= 4'b0000;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // Outputs: bus fields only while requesting, results only in the done cycle.
    always_comb begin
        o_lsu_stall     = ((state_q == S_IDLE) && i_lsu_valid) ||
                          (state_q == S_REQ) || (state_q == S_WAIT);
        o_lsu_done      = 1'b0;
        o_lsu_rdata     = '0;
        o_lsu_misalign  = 1'b0;
        o_lsu_err       = 1'b0;
        o_dmem_req      = 1'b0;
        o_dmem_addr     = '0;
        o_dmem_wen      = 1'b0;
        o_dmem_byte_sel = 4'b0000;
        o_dmem_wdata    = '0;
        if (state_q == S_DONE) begin
            o_lsu_done     = 1'b1;
            o_lsu_rdata    = rdata_q;
            o_lsu_misalign = misalign_q;
            o_lsu_err      = err_q;
        end
        if (state_q == S_REQ) begin
            o_dmem_req      = 1'b1;
            o_dmem_addr     = addr_q[DMEM_ADDR_BIT-1:2];
            o_dmem_wen      = we_q;
            o_dmem_byte_sel = sel_q;
            o_dmem_wdata    = wdata_q;
        end
    end

endmodule

// File: tb/tb_pipe_mem_lsu.sv
// tb_pipe_mem_lsu: scoreboard bench for pipe_mem_lsu (TIMEOUT_CYCLES=4).
// Tasks queue the expected completion of each access; a monitor pops and
// checks it when the done pulse appears.
module tb_pipe_mem_lsu;

    localparam int XLEN    = 32;
    localparam int DAB     = 14;
    localparam int TMO     = 4;
    localparam int MAX_CYC = 40;

    logic            i_clk = 1'b0;
    logic            i_rstn;
    logic            i_lsu_valid;
    logic            i_lsu_we;
    logic [2:0]      i_lsu_funct3;
    logic [31:0]     i_lsu_addr;
    logic [31:0]     i_lsu_wdata;
    logic            i_lsu_flush;
    logic            o_lsu_stall;
    logic            o_lsu_done;
    logic [31:0]     o_lsu_rdata;
    logic            o_lsu_misalign;
    logic            o_lsu_err;
    logic            o_dmem_req;
    logic            i_dmem_gnt;
    logic [DAB-3:0]  o_dmem_addr;
    logic            o_dmem_wen;
    logic [3:0]      o_dmem_byte_sel;
    logic [31:0]     o_dmem_wdata;
    logic            i_dmem_rvalid;
    logic [31:0]     i_dmem_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        misalign;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    int   tests_run    = 0;
    int   tests_failed = 0;

    pipe_mem_lsu #(.XLEN(XLEN), .DMEM_ADDR_BIT(DAB), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_lsu_valid(i_lsu_valid), .i_lsu_we(i_lsu_we), .i_lsu_funct3(i_lsu_funct3),
        .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata), .i_lsu_flush(i_lsu_flush),
        .o_lsu_stall(o_lsu_stall), .o_lsu_done(o_lsu_done), .o_lsu_rdata(o_lsu_rdata),
        .o_lsu_misalign(o_lsu_misalign), .o_lsu_err(o_lsu_err),
        .o_dmem_req(o_dmem_req), .i_dmem_gnt(i_dmem_gnt), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wen(o_dmem_wen), .o_dmem_byte_sel(o_dmem_byte_sel), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    always #5 i_clk = ~i_clk;

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always begin
        @(negedge i_clk);
        #2;
        if (o_lsu_done === 1'b1) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_done: got done with rdata=%h mis=%b err=%b, required no pulse",
                         o_lsu_rdata, o_lsu_misalign, o_lsu_err);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({o_lsu_rdata, o_lsu_misalign, o_lsu_err} !== {mon_exp.rdata, mon_exp.misalign, mon_exp.err}) begin
                    tests_failed++;
                    $display("[TB] FAIL done_result: got rdata=%h mis=%b err=%b, required rdata=%h mis=%b err=%b",
                             o_lsu_rdata, o_lsu_misalign, o_lsu_err, mon_exp.rdata, mon_exp.misalign, mon_exp.err);
                end
            end
        end
    end

    // Independent load-format model.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Drive one access starting at the next falling edge and play the memory
    // side: gnt on the gnt_at-th request cycle, rvalid on the rv_at-th wait
    // cycle (negative means never). Returns on the done cycle.
    task automatic run_access(
        input  logic        we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
        input  int          gnt_at, input int rv_at, input logic [31:0] mem_word, input bit flush_with_gnt,
        output int          stall_cnt, output int req_cnt, output int done_cyc, output logic stall_at_done,
        output logic [11:0] bus_addr, output logic [3:0] bus_sel, output logic bus_wen,
        output logic [31:0] bus_wdata, output bit bus_unstable);
        int wait_cnt;
        bit granted;
        stall_cnt = 0; req_cnt = 0; done_cyc = 0; stall_at_done = 1'b1;
        wait_cnt = 0; granted = 0; bus_unstable = 0;
        bus_addr = '0; bus_sel = '0; bus_wen = 1'b0; bus_wdata = '0;
        @(negedge i_clk);
        i_lsu_valid = 1'b1; i_lsu_we = we; i_lsu_funct3 = f3; i_lsu_addr = addr; i_lsu_wdata = wdata;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_lsu_flush = 1'b0; i_dmem_rdata = $urandom;
        for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
            #1;
            if (o_lsu_done === 1'b1) begin
                done_cyc      = cyc;
                stall_at_done = o_lsu_stall;
                break;
            end
            if (o_lsu_stall === 1'b1) stall_cnt++;
            if (o_dmem_req === 1'b1) begin
                if (req_cnt == 0) begin
                    bus_addr = o_dmem_addr; bus_sel = o_dmem_byte_sel;
                    bus_wen = o_dmem_wen; bus_wdata = o_dmem_wdata;
                end else if ({bus_addr, bus_sel, bus_wen, bus_wdata} !== {o_dmem_addr, o_dmem_byte_sel, o_dmem_wen, o_dmem_wdata}) begin
                    bus_unstable = 1;
                end
                if (req_cnt == gnt_at) begin
                    i_dmem_gnt = 1'b1;
                    granted = 1;
                    if (flush_with_gnt) i_lsu_flush = 1'b1;
                end
                req_cnt++;
            end else if (granted && o_lsu_stall === 1'b1) begin
                if (wait_cnt == rv_at) begin
                    i_dmem_rvalid = 1'b1;
                    i_dmem_rdata  = mem_word;
                end
                wait_cnt++;
            end
            @(negedge i_clk);
            i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_lsu_flush = 1'b0; i_dmem_rdata = $urandom;
        end
        i_lsu_valid = 1'b0;
        tests_run++;
        if (done_cyc == 0) begin
            tests_failed++;
            $display("[TB] FAIL done_bound: got no done within %0d cycles, required a done pulse", MAX_CYC);
        end
    endtask

    task automatic test_reset();
        i_rstn = 1'b0; i_lsu_valid = 1'b0; i_lsu_we = 1'b0; i_lsu_funct3 = 3'b000;
        i_lsu_addr = '0; i_lsu_wdata = '0; i_lsu_flush = 1'b0;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
        repeat (2) @(negedge i_clk);
        #1;
        tests_run++;
        if ({o_lsu_stall, o_lsu_done, o_lsu_misalign, o_lsu_err, o_dmem_req, o_dmem_wen, o_dmem_byte_sel,
             o_lsu_rdata, o_dmem_addr, o_dmem_wdata} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got stall=%b done=%b req=%b sel=%b rdata=%h, required all 0",
                     o_lsu_stall, o_lsu_done, o_lsu_req_str(), o_dmem_byte_sel, o_lsu_rdata);
        end
        @(negedge i_clk);
        i_rstn = 1'b1;
        repeat (2) @(negedge i_clk);
        #1;
        tests_run++;
        if ({o_lsu_stall, o_lsu_done, o_dmem_req} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: got stall=%b done=%b req=%b, required 000",
                     o_lsu_stall, o_lsu_done, o_dmem_req);
        end
    endtask

    function automatic logic o_lsu_req_str();
        return o_dmem_req;
    endfunction

    task automatic test_load_word();
        int s, r, d; logic sd; logic [11:0] ba; logic [3:0] bs; logic bw; logic [31:0] bd; bit bu;
        sb_q.push_back('{rdata: 32'hDEADBEEF, misalign: 1'b0, err: 1'b0});
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, s, r, d, sd, ba, bs, bw, bd, bu);
        tests_run++;
        if (s != 3 || d != 4 || sd !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lw_latency: got stall=%0d done_cyc=%0d stall_at_done=%b, required 3 4 0", s, d, sd);
        end
        tests_run++;
        if (r != 1 || bs !== 4'b1111 || ba !== 12'h040 || bw !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lw_bus: got req=%0d sel=%b addr=%h wen=%b, required 1 1111 040 0", r, bs, ba, bw);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3_t[7]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b100};
        logic [31:0] adr_t[7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100, 32'h100};
        logic [31:0] wrd_t[7] = '{32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233,
                                  32'h1234F6AB, 32'h00017FFE, 32'h123456FF};
        logic [31:0] exp_t_[7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011,
                                   32'hFFFFFFF6, 32'h00007FFE, 32'h000000FF};
        int s, r, d; logic sd; logic [11:0] ba; logic [3:0] bs; logic bw; logic [31:0] bd; bit bu;
        for (int i = 0; i < 7; i++) begin
            sb_q.push_back('{rdata: exp_t_[i], misalign: 1'b0, err: 1'b0});
            run_access(1'b0, f3_t[i], adr_t[i], 32'h0, 0, 0, wrd_t[i], 0, s, r, d, sd, ba, bs, bw, bd, bu);
            tests_run++;
            if (d != 4 || bs !== 4'b1111 || bw !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL load_ext_%0d: got done_cyc=%0d sel=%b wen=%b, required 4 1111 0", i, d, bs, bw);
            end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3_t[5]  = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001};
        logic [31:0] adr_t[5] = '{32'h201, 32'h202, 32'h204, 32'h203, 32'h200};
        logic [31:0] wd_t[5]  = '{32'h000000A5, 32'h1234BEEF, 32'h12345678, 32'h00000077, 32'hCAFE5A5A};
        logic [3:0]  sel_t[5] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000, 4'b0011};
        logic [31:0] bd_t[5]  = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h12345678, 32'h77777777, 32'h5A5A5A5A};
        int          gnt_t[5] = '{0, 0, 0, 2, 1};
        int s, r, d; logic sd; logic [11:0] ba; logic [3:0] bs; logic bw; logic [31:0] bd; bit bu;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back('{rdata: 32'h0, misalign: 1'b0, err: 1'b0});
            run_access(1'b1, f3_t[i], adr_t[i], wd_t[i], gnt_t[i], 0, 32'h0, 0, s, r, d, sd, ba, bs, bw, bd, bu);
            tests_run++;
            if (bs !== sel_t[i] || bd !== bd_t[i] || bw !== 1'b1 || ba !== adr_t[i][13:2] || bu) begin
                tests_failed++;
                $display("[TB] FAIL store_bus_%0d: got sel=%b wdata=%h wen=%b addr=%h unstable=%0d, required %b %h 1 %h 0",
                         i, bs, bd, bw, ba, bu, sel_t[i], bd_t[i], adr_t[i][13:2]);
            end
            tests_run++;
            if (s != 2 + gnt_t[i] || d != 3 + gnt_t[i]) begin
                tests_failed++;
                $display("[TB] FAIL store_latency_%0d: got stall=%0d done_cyc=%0d, required %0d %0d",
                         i, s, d, 2 + gnt_t[i], 3 + gnt_t[i]);
            end
        end
    endtask

    task automatic test_misalign();
        logic        we_t[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3_t[7]  = '{3'b010, 3'b011, 3'b001, 3'b100, 3'b001, 3'b110, 3'b111};
        logic [31:0] adr_t[7] = '{32'h102, 32'h100, 32'h201, 32'h100, 32'h101, 32'h100, 32'h200};
        int s, r, d; logic sd; logic [11:0] ba; logic [3:0] bs; logic bw; logic [31:0] bd; bit bu;
        for (int i = 0; i < 7; i++) begin
            sb_q.push_back('{rdata: 32'h0, misalign: 1'b1, err: 1'b0});
            run_access(we_t[i], f3_t[i], adr_t[i], 32'hFFFFFFFF, 0, 0, 32'h0, 0, s, r, d, sd, ba, bs, bw, bd, bu);
            tests_run++;
            if (r != 0 || s != 1 || d != 2) begin
                tests_failed++;
                $display("[TB] FAIL misalign_%0d: got req=%0d stall=%0d done_cyc=%0d, required 0 1 2", i, r, s, d);
            end
        end
    endtask

    task automatic test_timeout();
        logic        we_t[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          gnt_t[5] = '{-1, 3, 0, 0, -1};
        int          rv_t[5]  = '{0, 0, -1, 3, 0};
        logic [31:0] wrd_t[5] = '{32'h11111111, 32'h13572468, 32'h22222222, 32'h0BADF00D, 32'h0};
        exp_t        e_t[5]   = '{'{32'h0, 1'b0, 1'b1}, '{32'h13572468, 1'b0, 1'b0},
                                  '{32'h0, 1'b0, 1'b1}, '{32'h0BADF00D, 1'b0, 1'b0},
                                  '{32'h0, 1'b0, 1'b1}};
        int          dc_t[5]  = '{6, 7, 7, 7, 6};
        int          rq_t[5]  = '{4, 4, 1, 1, 4};
        int s, r, d; logic sd; logic [11:0] ba; logic [3:0] bs; logic bw; logic [31:0] bd; bit bu;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(e_t[i]);
            run_access(we_t[i], 3'b010, 32'h180, 32'h55555555, gnt_t[i], rv_t[i], wrd_t[i], 0,
                       s, r, d, sd, ba, bs, bw, bd, bu);
            tests_run++;
            if (d != dc_t[i] || r != rq_t[i] || s != dc_t[i] - 1) begin
                tests_failed++;
                $display("[TB] FAIL timeout_%0d: got done_cyc=%0d req=%0d stall=%0d, required %0d %0d %0d",
                         i, d, r, s, dc_t[i], rq_t[i], dc_t[i] - 1);
            end
        end
    endtask

    task automatic test_flush();
        bit seen;
        int s, r, d; logic sd; logic [11:0] ba; logic [3:0] bs; logic bw; logic [31:0] bd; bit bu;
        @(negedge i_clk);
        i_lsu_valid = 1'b1; i_lsu_we = 1'b0; i_lsu_funct3 = 3'b010; i_lsu_addr = 32'h100;
        @(negedge i_clk);
        #1;
        tests_run++;
        if (o_dmem_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_req_up: got req=%b, required 1", o_dmem_req);
        end
        i_lsu_flush = 1'b1;
        i_lsu_valid = 1'b0;
        @(negedge i_clk);
        i_lsu_flush   = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hBAD0BAD0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (o_lsu_done !== 1'b0 || o_dmem_req !== 1'b0 || o_lsu_stall !== 1'b0) seen = 1;
            @(negedge i_clk);
        end
        i_dmem_rvalid = 1'b0;
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("[TB] FAIL flush_abort: got activity after flush, required idle with no done");
        end
        // Grant and flush in the same cycle: the grant wins.
        sb_q.push_back('{rdata: 32'hA1B2C3D4, misalign: 1'b0, err: 1'b0});
        run_access(1'b0, 3'b010, 32'h108, 32'h0, 1, 0, 32'hA1B2C3D4, 1, s, r, d, sd, ba, bs, bw, bd, bu);
        tests_run++;
        if (d != 5 || r != 2) begin
            tests_failed++;
            $display("[TB] FAIL gnt_beats_flush: got done_cyc=%0d req=%0d, required 5 2", d, r);
        end
    endtask

    task automatic test_reset_mid_wait();
        int s, r, d; logic sd; logic [11:0] ba; logic [3:0] bs; logic bw; logic [31:0] bd; bit bu;
        @(negedge i_clk);
        i_lsu_valid = 1'b1; i_lsu_we = 1'b0; i_lsu_funct3 = 3'b010; i_lsu_addr = 32'h100;
        @(negedge i_clk);
        #1;
        i_dmem_gnt = 1'b1;
        @(negedge i_clk);
        i_dmem_gnt  = 1'b0;
        i_lsu_valid = 1'b0;
        #1;
        tests_run++;
        if ({o_lsu_stall, o_dmem_req, o_lsu_done} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL wait_state: got stall/req/done=%b%b%b, required 100", o_lsu_stall, o_dmem_req, o_lsu_done);
        end
        #2;
        i_rstn = 1'b0;
        #1;
        tests_run++;
        if ({o_lsu_stall, o_dmem_req, o_lsu_done, o_lsu_rdata, o_dmem_byte_sel} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got stall=%b req=%b done=%b, required 000", o_lsu_stall, o_dmem_req, o_lsu_done);
        end
        @(negedge i_clk);
        i_rstn = 1'b1;
        sb_q.push_back('{rdata: 32'h55AA33CC, misalign: 1'b0, err: 1'b0});
        run_access(1'b0, 3'b010, 32'h104, 32'h0, 0, 0, 32'h55AA33CC, 0, s, r, d, sd, ba, bs, bw, bd, bu);
        tests_run++;
        if (d != 4 || ba !== 12'h041) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_lw: got done_cyc=%0d addr=%h, required 4 041", d, ba);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] f3_map[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        int s, r, d; logic sd; logic [11:0] ba; logic [3:0] bs; logic bw; logic [31:0] bd; bit bu;
        for (int i = 0; i < 10; i++) begin
            logic        we;
            int          idx, g, v, exp_d;
            logic [2:0]  f3;
            logic [1:0]  off;
            logic [31:0] adr, word;
            we   = 1'($urandom_range(0, 1));
            idx  = $urandom_range(0, 4);
            if (we && idx >= 3) idx = idx - 3;
            f3   = f3_map[idx];
            off  = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) off[0] = 1'b0;
            if (f3[1:0] == 2'b10) off = 2'b00;
            adr  = 32'h300 + 32'($urandom_range(0, 15)) * 4 + {30'h0, off};
            word = $urandom;
            g    = $urandom_range(0, 2);
            v    = $urandom_range(0, 2);
            sb_q.push_back('{rdata: we ? 32'h0 : model_load(f3, off, word), misalign: 1'b0, err: 1'b0});
            run_access(we, f3, adr, $urandom, g, v, word, 0, s, r, d, sd, ba, bs, bw, bd, bu);
            exp_d = 3 + g + (we ? 0 : v + 1);
            tests_run++;
            if (d != exp_d || sd !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL b2b_%0d: got done_cyc=%0d stall_at_done=%b, required %0d 0", i, d, sd, exp_d);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_misalign();
        test_timeout();
        test_flush();
        test_reset_mid_wait();
        test_back_to_back();
        repeat (3) @(negedge i_clk);
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL pending_expect: got %0d outstanding expectations, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_mem_lsu.md
Name: pipe_mem_lsu

Overview:
Parametrised load/store unit for the pipelined RV32I Memory stage. It replaces the single-cycle dmem access with a request/grant/response handshake to a variable-latency data memory. It stalls the pipeline while an access is outstanding and generates byte lanes for stores and sign/zero extension for loads. It also flags misaligned accesses and bus timeouts.

Parameters:
XLEN, 32, datapath width (only 32 is supported; byte-lane logic assumes 4 lanes)
DMEM_ADDR_BIT, 14, byte-address bits decoded by data memory
TIMEOUT_CYCLES, 15, max cycles waiting for grant or response before error; 0 disables timeout

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_lsu_valid  in  1  Memory-stage instruction is a load/store
i_lsu_we  in  1  1=store, 0=load
i_lsu_funct3  in  3  RV32I load/store funct3
i_lsu_addr  in  XLEN  effective byte address (ALUResultM)
i_lsu_wdata  in  XLEN  store data (WriteDataM)
i_lsu_flush  in  1  abort request not yet granted
o_lsu_stall  out  1  hold IF..MEM stages
o_lsu_done  out  1  one-cycle completion pulse
o_lsu_rdata  out  XLEN  formatted load data, valid with o_lsu_done
o_lsu_misalign  out  1  misaligned/illegal access, valid with o_lsu_done
o_lsu_err  out  1  timeout error, valid with o_lsu_done
o_dmem_req  out  1  memory request
i_dmem_gnt  in  1  request accepted
o_dmem_addr  out  DMEM_ADDR_BIT-2  word address
o_dmem_wen  out  1  write enable
o_dmem_byte_sel  out  4  byte-lane enables
o_dmem_wdata  out  XLEN  lane-replicated store data
i_dmem_rvalid  in  1  read response valid
i_dmem_rdata  in  XLEN  read word

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: when i_lsu_valid=1, register addr, we, funct3, lanes and wdata.
  - Misaligned or illegal request -> DONE with misalign=1 and no bus request.
  - Otherwise -> REQ.
- Misaligned/illegal definitions:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - funct3 in {011,110,111}, or store funct3 in {100,101}.
- REQ: o_dmem_req=1; addr, wen, byte_sel and wdata are driven from registers and held stable until grant.
  - i_dmem_gnt with store -> DONE.
  - i_dmem_gnt with load -> WAIT.
  - i_lsu_flush=1 with no gnt -> IDLE; no done pulse.
  - gnt and flush in the same cycle -> gnt wins.
- WAIT: i_dmem_rvalid -> capture formatted data, go to DONE. Flush is ignored in WAIT.
- DONE: o_lsu_done=1 for one cycle, with rdata/misalign/err held; then -> IDLE.
  - All DONE-qualified outputs return to 0 in IDLE.
- Stall: o_lsu_stall = (IDLE & i_lsu_valid) | REQ | WAIT. It is 0 in DONE, so the pipeline advances on the DONE cycle.
- Minimum latency:
  - load, gnt in first REQ cycle, rvalid next cycle: accept cycle + REQ + WAIT = 3 stall cycles, done in the 4th cycle;
  - store, gnt in first REQ cycle: 2 stall cycles.
- Store lanes (wdata replicated per lane):
  - SB: byte_sel = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}};
  - SH: byte_sel = 4'b0011<<{addr[1],1'b0}, wdata = {2{wdata[15:0]}};
  - SW: byte_sel = 4'b1111.
- Loads: byte_sel = 4'b1111, wen = 0.
- Load format: lane selected by addr[1:0].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word.
- o_dmem_addr = addr[DMEM_ADDR_BIT-1:2]; upper address bits are ignored.
- Timeout: counter clears on entry to REQ or WAIT and increments each cycle without gnt (REQ) or rvalid (WAIT).
  - When it reaches TIMEOUT_CYCLES -> DONE with err=1, rdata=0.
  - A gnt/rvalid arriving in the terminal cycle wins over the timeout.
- Stray i_dmem_rvalid in IDLE, REQ or DONE is ignored. rvalid is never expected in the same cycle as gnt.
- Asynchronous reset mid-access: immediately IDLE, outputs 0, req dropped.

Test Plan:
- LW addr=0x100, gnt in first REQ cycle, rdata=0xDEADBEEF one cycle later -> stall high 3 cycles, done pulse with rdata=0xDEADBEEF, byte_sel=4'b1111, o_dmem_addr=0x40.
- LB addr=0x103, rdata=0x80112233 -> rdata=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x102 -> 0xFFFF8011.
- SB addr=0x201, wdata=0x000000A5 -> byte_sel=4'b0010, wdata=0xA5A5A5A5, wen=1, done 2 cycles after accept with no WAIT; SH addr=0x202 -> byte_sel=4'b1100.
- LW addr=0x102 -> no o_dmem_req ever, done+misalign next cycle, stall for exactly 1 cycle; funct3=3'b011 -> same.
- TIMEOUT_CYCLES=4, gnt held low -> done+err after 4 REQ cycles, rdata=0; repeat with gnt on 4th cycle -> normal completion, err=0.
- Flush in REQ before gnt -> IDLE, no done pulse; assert i_rstn=0 during WAIT -> req/stall/done all 0 asynchronously, a later LW completes normally.
